seq_multiplier: RTL and testbench

- Parametrised, handshake-driven shift-and-add multiplier.
- Successor to the team's fixed 8-bit combinational array multiplier.
- Trades area for latency: one partial-product row is added per clock, giving a WIDTH-cycle compute.
- Sits between a producer and a consumer on valid/ready streams.
- Optional signed mode.

---
 rtl/seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_seq_multiplier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: handshake-driven shift-and-add multiplier.
// Adds one partial-product row per clock, so a product takes WIDTH cycles.
// Operands enter on a valid/ready stream; the product leaves on another.
// Optional build macro SEQ_MULT_SIGNED_EN adds a signed_mode input.
// When that input is set, a and b are two's complement. The block multiplies
// their magnitudes and negates the result on the final step, so latency is unchanged.
`timescale 1ns/1ps

module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;       // registered multiplicand (magnitude)
    logic [WIDTH-1:0]     b_q, b_d;       // multiplier; low product bits shift in at the top
    logic [WIDTH-1:0]     hi_q, hi_d;     // upper half of the running accumulator
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 neg_q, neg_d;   // final result must be negated

    logic [WIDTH:0]       add_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   final_s;

`ifdef SEQ_MULT_SIGNED_EN
    // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) begin
            mag = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
    endfunction
`endif

    // One shift-and-add step; the add is WIDTH+1 bits wide so the carry is kept.
    always_comb begin
        add_s   = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        prod_s  = {add_s, b_q[WIDTH-1:1]};
        final_s = neg_q ? ((~prod_s) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
    end

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_MULT_SIGNED_EN
                    a_d   = mag(a, signed_mode);
                    b_d   = mag(b, signed_mode);
                    neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
                    a_d   = a;
                    b_d   = b;
                    neg_d = 1'b0;
`endif
                    hi_d    = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                hi_d = add_s[WIDTH:1];
                b_d  = {add_s[0], b_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    p_d     = final_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            p_q     <= {(2*WIDTH){1'b0}};
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
        end
    end

    // Outputs decode registered state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier.
// An 8-bit instance takes directed and random traffic. A 16-bit instance
// covers the wider maximum-value case.
`timescale 1ns/1ps

module tb_seq_multiplier;

    localparam int W  = 8;
    localparam int WH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid, in_ready, out_valid, out_ready, busy, sm;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;

    logic            in_valid_h, in_ready_h, out_valid_h, out_ready_h, busy_h;
    logic [WH-1:0]   a_h, b_h;
    logic [2*WH-1:0] p_h;

    seq_multiplier #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(sm),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .P(p), .busy(busy)
    );

    seq_multiplier #(.WIDTH(WH)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .a(a_h), .b(b_h),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .out_valid(out_valid_h), .out_ready(out_ready_h), .P(p_h), .busy(busy_h)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] prod;
        int          acc_edge;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t acc_e, out_e, acc_eh, out_eh;
    int   n_acc = 0, n_acc_h = 0;
    int   last_acc = -1;
    bit   stream_mode = 1'b0;
    logic prev_ov = 1'b0, prev_ov_h = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=event missing or unexpected required=consistent handshake", name);
    endtask

    // Reference: plain integer products, signed or unsigned.
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input int width, input logic s);
        longint xs, ys, pr;
        logic [63:0] r;
        xs = longint'(x);
        ys = longint'(y);
        if (s) begin
            if (x[width-1]) xs = xs - (longint'(1) << width);
            if (y[width-1]) ys = ys - (longint'(1) << width);
        end
        pr = xs * ys;
        r  = pr;
        if (2 * width < 64) r = r & ((64'd1 << (2 * width)) - 64'd1);
        return r;
    endfunction

    // Record expected result when the 8-bit instance accepts operands.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_e.prod     = model(64'(a), 64'(b), W, sm);
            acc_e.acc_edge = cyc + 1;
            q8.push_back(acc_e);
            n_acc++;
            if (stream_mode && last_acc >= 0) chk("throughput", 64'(cyc + 1 - last_acc), 64'(W + 2));
            last_acc = cyc + 1;
        end
    end

    // Check latency and product of the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q8.size() == 0) fail("unexpected_out_valid");
                else chk("latency", 64'(cyc - q8[0].acc_edge), 64'(W));
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    fail("unexpected_product");
                end else begin
                    out_e = q8.pop_front();
                    chk("product", 64'(p), out_e.prod);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Record expected result for the 16-bit instance.
    always @(negedge clk) begin
        if (rst_n && in_valid_h && in_ready_h) begin
            acc_eh.prod     = model(64'(a_h), 64'(b_h), WH, 1'b0);
            acc_eh.acc_edge = cyc + 1;
            q16.push_back(acc_eh);
            n_acc_h++;
        end
    end

    // Check latency and product of the 16-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov_h = 1'b0;
        end else begin
            if (out_valid_h && !prev_ov_h) begin
                if (q16.size() == 0) fail("unexpected_out_valid16");
                else chk("latency16", 64'(cyc - q16[0].acc_edge), 64'(WH));
            end
            if (out_valid_h && out_ready_h) begin
                if (q16.size() == 0) begin
                    fail("unexpected_product16");
                end else begin
                    out_eh = q16.pop_front();
                    chk("product16", 64'(p_h), out_eh.prod);
                end
            end
            prev_ov_h = out_valid_h;
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int k0;
        bit ok;
        k0 = n_acc;
        ok = 1'b0;
        a = x; b = y; sm = s; in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (n_acc > k0) begin ok = 1'b1; break; end
        end
        #1;
        in_valid = 1'b0;
        if (!ok) fail("accept_timeout");
        else chk("calc_flags", 64'({in_ready, busy}), 64'(2'b01));
    endtask

    task automatic issue16(input logic [WH-1:0] x, input logic [WH-1:0] y);
        int k0;
        bit ok;
        k0 = n_acc_h;
        ok = 1'b0;
        a_h = x; b_h = y; in_valid_h = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (n_acc_h > k0) begin ok = 1'b1; break; end
        end
        #1;
        in_valid_h = 1'b0;
        if (!ok) fail("accept_timeout16");
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (q8.size() == 0 && q16.size() == 0) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) fail("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2*W-1:0] bp_exp;
        int target, ov_cnt;
        bit ok;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sm = 1'b0;
        in_valid_h = 1'b0; out_ready_h = 1'b0; a_h = '0; b_h = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'({in_ready, out_valid, busy, p}), 64'({1'b1, 1'b0, 1'b0, 16'h0000}));
        chk("reset_state16", 64'({in_ready_h, out_valid_h, busy_h}), 64'(3'b100));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed unsigned operands, consumer always ready.
        out_ready = 1'b1;
        issue(8'h0D, 8'h0B, 1'b0); wait_drain();
        issue(8'hFF, 8'hFF, 1'b0); wait_drain();
        issue(8'h00, 8'hAB, 1'b0); wait_drain();
        issue(8'h5A, 8'h00, 1'b0); wait_drain();
        issue(8'h80, 8'h02, 1'b0); wait_drain();

        // Operands and in_valid change while the product is being computed.
        issue(8'h03, 8'h05, 1'b0);
        for (int i = 0; i < W - 1; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();

        // Backpressure: consumer stalls for 20 cycles.
        out_ready = 1'b0;
        bp_exp = 16'(model(64'h00C3, 64'h005A, W, 1'b0));
        issue(8'hC3, 8'h5A, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail("bp_out_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({out_valid, in_ready, p}), 64'({1'b1, 1'b0, bp_exp}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("p_retained", 64'(p), 64'(bp_exp));
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a calculation.
        issue(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q8.delete();
        chk("reset_mid_calc", 64'({out_valid, in_ready, busy, p}), 64'({1'b0, 1'b1, 1'b0, 16'h0000}));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("no_ov_after_reset", 64'(ov_cnt), 64'd0);
        chk("after_reset_idle", 64'({in_ready, p}), 64'({1'b1, 16'h0000}));
        @(posedge clk); #1;

        // Back-to-back random stream with in_valid held high.
        stream_mode = 1'b1;
        last_acc = -1;
        target = n_acc + 100;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 * (W + 2) + 100; t++) begin
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            if (n_acc >= target) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) fail("stream_timeout");
        stream_mode = 1'b0;
        wait_drain();

`ifdef SEQ_MULT_SIGNED_EN
        // Signed and unsigned interpretations of the same operands.
        issue(8'hFD, 8'h05, 1'b1); wait_drain();
        issue(8'h80, 8'h80, 1'b1); wait_drain();
        issue(8'hFD, 8'h05, 1'b0); wait_drain();
        issue(8'h80, 8'h80, 1'b0); wait_drain();
        for (int i = 0; i < 20; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom));
            wait_drain();
        end
        sm = 1'b0;
`endif

        // Wider instance: maximum operands and a few random pairs.
        out_ready_h = 1'b1;
        issue16(16'hFFFF, 16'hFFFF); wait_drain();
        issue16(16'h0000, 16'h1234); wait_drain();
        for (int i = 0; i < 6; i++) begin
            issue16(16'($urandom), 16'($urandom));
            wait_drain();
        end
        chk("wide_max_value", model(64'hFFFF, 64'hFFFF, WH, 1'b0), 64'hFFFE0001);

        chk("queues_empty", 64'(q8.size() + q16.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
